lcg_step_ctrl: RTL and testbench

- Sequencer for one N-bit linear-congruential step, x_next = (A*x + C) mod 2^N.
- Uses a single shared pg_adder (propagate/generate adder) instance for every addition.
- Multiplication is shift-and-add, one partial product per cycle; a final cycle adds the increment.
- Sits between the MDCLCG top level (start/load handshake) and the PG-cell datapath.

---
 rtl/lcg_step_ctrl_pkg.sv | 26 ++
 rtl/lcg_step_ctrl_if.sv | 25 ++
 rtl/lcg_step_ctrl_pg_adder.sv | 26 ++
 rtl/lcg_step_ctrl.sv | 118 +++++++++++
 tb/tb_lcg_step_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lcg_step_ctrl_pkg.sv
// Shared types and constants for the LCG step sequencer and its testbench.
package lcg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADDC = 2'd2,
        DONE = 2'd3
    } lcg_state_e;

    localparam int LCG_N = 8;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/lcg_step_ctrl_if.sv
// Start/load handshake and result bus between the MDCLCG top level and the step sequencer.
interface lcg_step_ctrl_if import lcg_pkg::*; #(
    parameter int N = LCG_N
) ();

    logic         load;
    logic [N-1:0] seed;
    logic         start;
    logic [N-1:0] a_mult;
    logic [N-1:0] c_inc;
    logic         busy;
    logic         done;
    logic [N-1:0] x_out;

    modport master (
        output load, seed, start, a_mult, c_inc,
        input  busy, done, x_out
    );

    modport slave (
        input  load, seed, start, a_mult, c_inc,
        output busy, done, x_out
    );

endinterface

// File: rtl/lcg_step_ctrl_pg_adder.sv
// N-bit combinational ripple adder built from per-bit propagate/generate cells.
module pg_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] w_p;
    logic [N-1:0] w_g;
    logic [N:0]   w_c;

    assign w_p    = a ^ b;
    assign w_g    = a & b;
    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_carry
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign sum  = w_p ^ w_c[N-1:0];
    assign cout = w_c[N];

endmodule

// File: rtl/lcg_step_ctrl.sv
// One LCG step x_next = (A*x + C) mod 2^N via shift-and-add on a single shared pg_adder.
// Define LCG_EARLY_TERM_EN to leave the multiply as soon as the remaining multiplier bits are zero.
module lcg_step_ctrl import lcg_pkg::*; #(
    parameter int           N    = LCG_N,
    parameter logic [N-1:0] SEED = N'(1)
) (
    input  logic           clk,
    input  logic           rst,
    lcg_step_ctrl_if.slave bus
);

    localparam int            CW       = clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    lcg_state_e   r_state;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_mcand;
    logic [N-1:0] r_mplier;
    logic [N-1:0] r_creg;
    logic [CW-1:0] r_cnt;
    logic [N-1:0] r_x;
    logic         r_busy;
    logic         r_done;

    logic [N-1:0] w_addA;
    logic [N-1:0] w_addB;
    logic [N-1:0] w_sum;
    logic         w_unused_cout;
    logic         w_mulLast;

    // Adder operands are zero outside MUL/ADDC so the shared adder idles quietly.
    always_comb begin
        w_addA = '0;
        w_addB = '0;
        case (r_state)
            MUL: begin
                w_addA = r_acc;
                w_addB = r_mplier[0] ? r_mcand : '0;
            end
            ADDC: begin
                w_addA = r_acc;
                w_addB = r_creg;
            end
            default: begin
                w_addA = '0;
                w_addB = '0;
            end
        endcase
    end

    pg_adder #(.N(N)) u_adder (
        .a    (w_addA),
        .b    (w_addB),
        .sum  (w_sum),
        .cout (w_unused_cout)
    );

`ifdef LCG_EARLY_TERM_EN
    assign w_mulLast = (r_cnt == CNT_LAST) || (r_mplier[N-1:1] == '0);
`else
    assign w_mulLast = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= SEED;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_creg   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_x <= bus.seed;
                    end else if (bus.start) begin
                        r_acc    <= '0;
                        r_mcand  <= r_x;
                        r_mplier <= bus.a_mult;
                        r_creg   <= bus.c_inc;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_mulLast) begin
                        r_state <= ADDC;
                    end
                end
                ADDC: begin
                    r_x     <= w_sum;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.x_out = r_x;

endmodule

// File: tb/tb_lcg_step_ctrl.sv
// Self-checking bench for lcg_step_ctrl: a step-level model checked every cycle plus literal pins.
// Expected latencies follow LCG_EARLY_TERM_EN when the bench is built with it.
module tb_lcg_step_ctrl;
    import lcg_pkg::*;

    localparam int           N    = 8;
    localparam logic [N-1:0] SEED = 8'd1;
`ifdef LCG_EARLY_TERM_EN
    localparam int LAT_A5 = 5;
    localparam int LAT_A0 = 3;
`else
    localparam int LAT_A5 = 10;
    localparam int LAT_A0 = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcg_step_ctrl_if #(.N(N)) bus ();

    lcg_step_ctrl #(.N(N), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int errorCount = 0;

    logic [N-1:0] mX;
    logic [N-1:0] mPending;
    logic         mBusy;
    logic         mDone;
    int           mRemain;
    logic         modelValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N-1:0] lcgNext(input logic [N-1:0] x, input logic [N-1:0] a, input logic [N-1:0] c);
        return N'((int'(a) * int'(x) + int'(c)) % (1 << N));
    endfunction

    // Number of multiply cycles a step spends for multiplier a.
    function automatic int mulCycles(input logic [N-1:0] a);
`ifdef LCG_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < N; i++) if (a[i]) msb = i;
        return (msb + 1 < 1) ? 1 : msb + 1;
`else
        return (a === a) ? N : N;
`endif
    endfunction

    // Step-level model: accepted start schedules the result mulCycles+1 edges later.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            mX         = SEED;
            mBusy      = 1'b0;
            mDone      = 1'b0;
            mRemain    = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (!mBusy) begin
                if (bus.load) begin
                    mX = bus.seed;
                end else if (bus.start) begin
                    mBusy    = 1'b1;
                    mPending = lcgNext(mX, bus.a_mult, bus.c_inc);
                    mRemain  = mulCycles(bus.a_mult) + 1;
                end
            end else if (mDone) begin
                mDone = 1'b0;
                mBusy = 1'b0;
            end else begin
                mRemain--;
                if (mRemain == 0) begin
                    mDone = 1'b1;
                    mX    = mPending;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_x_out", 32'(bus.x_out), 32'(mX));
            checkOutput("model_busy", 32'(bus.busy), 32'(mBusy));
            checkOutput("model_done", 32'(bus.done), 32'(mDone));
        end
    end

    task automatic applyStimulus(input logic l, input logic [N-1:0] sd, input logic s,
                                 input logic [N-1:0] a, input logic [N-1:0] c);
        @(negedge clk);
        bus.load   = l;
        bus.seed   = sd;
        bus.start  = s;
        bus.a_mult = a;
        bus.c_inc  = c;
    endtask

    // Issues one start and returns the period count until done is seen (bounded).
    task automatic runStep(input logic [N-1:0] a, input logic [N-1:0] c, output int lat);
        applyStimulus(1'b0, '0, 1'b1, a, c);
        lat = 0;
        while (1) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0);
            lat++;
            if (bus.done) break;
            if (lat > 100) begin
                errorCount++;
                $display("[TB] FAIL done_timeout actual=no_done expected=done");
                break;
            end
        end
    endtask

    int lat;
    int doneCount;
    logic [N-1:0] expChain [4] = '{8'd8, 8'd43, 8'd218, 8'd69};

    initial begin
        bus.load = 1'b0; bus.seed = '0; bus.start = 1'b0; bus.a_mult = '0; bus.c_inc = '0;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        checkOutput("reset_x_out", 32'(bus.x_out), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        applyStimulus(1'b1, 8'd1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            runStep(8'd5, 8'd3, lat);
            checkOutput("chain_x_out", 32'(bus.x_out), 32'(expChain[i]));
            checkOutput("chain_latency", 32'(lat), 32'(LAT_A5));
        end

        bus.start = 1'b1; bus.a_mult = 8'd7; bus.c_inc = 8'd7;
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        checkOutput("start_in_done_ignored", 32'(bus.busy), 32'd0);

        applyStimulus(1'b1, 8'h7F, 1'b1, 8'd3, 8'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        checkOutput("load_priority_x", 32'(bus.x_out), 32'h7F);
        checkOutput("load_priority_busy", 32'(bus.busy), 32'd0);

        applyStimulus(1'b0, '0, 1'b1, 8'd3, 8'd1);
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, (i == 1 || i == 4 || i == 7), 8'hAA, 8'h55);
            if (bus.done) doneCount++;
        end
        checkOutput("busy_start_single_done", 32'(doneCount), 32'd1);
        checkOutput("busy_start_x", 32'(bus.x_out), 32'h7E);

        applyStimulus(1'b1, 8'h02, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 8'hFF, 8'h01);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0);
        checkOutput("midrst_x", 32'(bus.x_out), 32'd1);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0);
            if (bus.done) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);

        applyStimulus(1'b1, 8'h33, 1'b0, '0, '0);
        runStep(8'd0, 8'h9A, lat);
        checkOutput("a0_x", 32'(bus.x_out), 32'h9A);
        checkOutput("a0_latency", 32'(lat), 32'(LAT_A0));
        runStep(8'd1, 8'd0, lat);
        checkOutput("a1_x_unchanged", 32'(bus.x_out), 32'h9A);
        checkOutput("a1_done", 32'(bus.done), 32'd1);
        applyStimulus(1'b1, 8'hFF, 1'b0, '0, '0);
        runStep(8'hFF, 8'hFF, lat);
        checkOutput("wrap_ff_x", 32'(bus.x_out), 32'h00);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, N'($urandom), $urandom_range(0, 3) == 0,
                          N'($urandom), N'($urandom));
            rst = ($urandom_range(0, 59) == 0);
        end
        rst = 1'b0;
        repeat (15) applyStimulus(1'b0, '0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
